sync_fifo_flags: RTL and testbench



---
 rtl/sync_fifo_flags.sv | 140 ++++++++++++++
 tb/tb_sync_fifo_flags.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_flags.sv
// Single-clock synchronous FIFO with occupancy count, programmable almost flags and a read-valid strobe.
// Optional sticky overflow/underflow outputs are enabled by defining SYNC_FIFO_ERR_EN.
module sync_fifo_flags #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             rd_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
`ifdef SYNC_FIFO_ERR_EN
  output logic             ovf,
  output logic             udf,
`endif
  output logic [AW:0]      count
);

  if (AF_THRESH < 0 || AF_THRESH > DEPTH) begin : g_bad_af_thresh
    $error("sync_fifo_flags: AF_THRESH must lie in 0..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH) begin : g_bad_ae_thresh
    $error("sync_fifo_flags: AE_THRESH must lie in 0..DEPTH");
  end
  if (DEPTH < 2 || DEPTH > 1024 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo_flags: DEPTH must be a power of two in 2..1024");
  end

  localparam logic [AW:0] AF_L = (AW + 1)'(AF_THRESH);
  localparam logic [AW:0] AE_L = (AW + 1)'(AE_THRESH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             rd_valid_q, rd_valid_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             almost_full_q, almost_full_d;
  logic             almost_empty_q, almost_empty_d;
  logic             rd_ok, wr_ok;

  // Handshake: a read is taken when rd_en is high and the FIFO is not empty; a write is
  // taken when wr_en is high and there is room, where a same-cycle accepted read frees a slot.
  always_comb begin
    rd_ok          = rd_en & ~empty_q;
    wr_ok          = wr_en & (~full_q | rd_ok);
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    dout_d         = dout_q;
    rd_valid_d     = rd_ok;
    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      dout_d   = mem_q[rd_ptr_q[AW-1:0]];
    end
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Flags come from next-state values so they line up with count every cycle.
    empty_d        = (wr_ptr_d == rd_ptr_d);
    full_d         = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) && (wr_ptr_d[AW] != rd_ptr_d[AW]);
    almost_full_d  = (count_d >= AF_L);
    almost_empty_d = (count_d <= AE_L);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      dout_q         <= '0;
      rd_valid_q     <= 1'b0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= (AF_THRESH == 0);
      almost_empty_q <= 1'b1;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      dout_q         <= dout_d;
      rd_valid_q     <= rd_valid_d;
      full_q         <= full_d;
      empty_q        <= empty_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
    end
  end

  // Storage is never cleared; reset only blocks the write in that cycle.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

`ifdef SYNC_FIFO_ERR_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  always_comb begin
    ovf_d = ovf_q | (wr_en & ~wr_ok);
    udf_d = udf_q | (rd_en & empty_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign ovf = ovf_q;
  assign udf = udf_q;
`endif

  assign dout         = dout_q;
  assign rd_valid     = rd_valid_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
  assign count        = count_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags (WIDTH=8, DEPTH=4, AF=3, AE=1): a queue-based reference model
// predicts flags each cycle and a monitor matches every rd_valid word against expected data.
module tb_sync_fifo_flags;
  localparam int W   = 8;
  localparam int D   = 4;
  localparam int AFT = 3;
  localparam int AET = 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wr_en = 1'b0;
  logic         rd_en = 1'b0;
  logic [W-1:0] din = '0;
  logic [W-1:0] dout;
  logic         rd_valid, full, empty, almost_full, almost_empty;
  logic [2:0]   count;
`ifdef SYNC_FIFO_ERR_EN
  logic         ovf, udf;
`endif

  sync_fifo_flags #(.WIDTH(W), .DEPTH(D), .AF_THRESH(AFT), .AE_THRESH(AET)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(dout), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
`ifdef SYNC_FIFO_ERR_EN
    .ovf(ovf), .udf(udf),
`endif
    .count(count)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // reference model and scoreboard state
  logic [W-1:0] model_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_dout = '0;
  bit           exp_rv   = 1'b0;
  bit           exp_ovf  = 1'b0;
  bit           exp_udf  = 1'b0;
  int           n_checks = 0;
  int           n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state();
    int sz;
    sz = model_q.size();
    check("count",        32'(count),        32'(sz));
    check("full",         32'(full),         32'(sz == D));
    check("empty",        32'(empty),        32'(sz == 0));
    check("almost_full",  32'(almost_full),  32'(sz >= AFT));
    check("almost_empty", 32'(almost_empty), 32'(sz <= AET));
    check("rd_valid",     32'(rd_valid),     32'(exp_rv));
    check("dout_held",    32'(dout),         32'(exp_dout));
`ifdef SYNC_FIFO_ERR_EN
    check("ovf",          32'(ovf),          32'(exp_ovf));
    check("udf",          32'(udf),          32'(exp_udf));
`endif
  endtask

  // driver tasks: inputs change 1ns after the rising edge, state is checked at the same point
  task automatic cycle(input bit wr, input bit rd, input logic [W-1:0] d);
    bit rok, wok;
    wr_en = wr;
    rd_en = rd;
    din   = d;
    rok   = rd && (model_q.size() > 0);
    wok   = wr && ((model_q.size() < D) || rok);
    if (wr && !wok) exp_ovf = 1'b1;
    if (rd && model_q.size() == 0) exp_udf = 1'b1;
    if (rok) begin
      exp_dout = model_q.pop_front();
      exp_q.push_back(exp_dout);
    end
    if (wok) model_q.push_back(d);
    exp_rv = rok;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    check_state();
  endtask

  task automatic do_reset(input bit wr, input bit rd);
    rst   = 1'b1;
    wr_en = wr;
    rd_en = rd;
    din   = W'($urandom_range(0, 255));
    @(posedge clk);
    #1;
    rst   = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    model_q.delete();
    exp_q.delete();
    exp_dout = '0;
    exp_rv   = 1'b0;
    exp_ovf  = 1'b0;
    exp_udf  = 1'b0;
    check_state();
  endtask

  // monitor: every rd_valid pulse must carry the oldest outstanding expected word
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) check("spurious_rd_valid", 32'd1, 32'd0);
      else check("dout_order", 32'(dout), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    int wr_pct, rd_pct;
    do_reset(1'b0, 1'b0);

    // fill to full, then a dropped write while full
    cycle(1, 0, 8'h11);
    cycle(1, 0, 8'h22);
    cycle(1, 0, 8'h33);
    cycle(1, 0, 8'h44);
    cycle(1, 0, 8'h55);
    // drain: 0x11..0x44 in order, no 0x55
    for (int i = 0; i < 4; i++) cycle(0, 1, 8'h00);
    cycle(0, 0, 8'h00);

    // read while empty after reset
    do_reset(1'b0, 1'b0);
    cycle(0, 1, 8'h00);
    cycle(0, 0, 8'h00);

    // simultaneous write/read at full, then at empty
    for (int i = 0; i < 4; i++) cycle(1, 0, W'(8'hA0 + i));
    cycle(1, 1, 8'hB0);
    for (int i = 0; i < 4; i++) cycle(0, 1, 8'h00);
    cycle(1, 1, 8'hC0);
    cycle(0, 1, 8'h00);

    // continuous push/pop across pointer wrap, then reset with count=2 and requests active
    do_reset(1'b0, 1'b0);
    cycle(1, 0, 8'h01);
    cycle(1, 0, 8'h02);
    for (int i = 0; i < 10; i++) cycle(1, 1, W'(8'h10 + i));
    do_reset(1'b1, 1'b1);
    cycle(0, 1, 8'h00);

    // randomized traffic with shifting write/read bias and occasional reset
    for (int i = 0; i < 600; i++) begin
      case ((i / 100) % 3)
        0:       begin wr_pct = 80; rd_pct = 30; end
        1:       begin wr_pct = 30; rd_pct = 80; end
        default: begin wr_pct = 60; rd_pct = 60; end
      endcase
      if ($urandom_range(0, 99) < 2) do_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else cycle($urandom_range(0, 99) < wr_pct, $urandom_range(0, 99) < rd_pct,
                 W'($urandom_range(0, 255)));
    end

    cycle(0, 0, 8'h00);
    @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
